// File: rtl/game_pkg.sv
// Shared types and default timing constants for the Flappy Birds game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLAY   = 3'd1,
    PAUSED = 3'd2,
    RESUME = 3'd3,
    OVER   = 3'd4
  } game_state_t;

  localparam int BLINK_TICKS_DEF  = 4;
  localparam int RESUME_TICKS_DEF = 3;

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for an already-synchronized key level.
// History resets to 1 so a key held through reset never reports a press.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  logic key_q;

  always_ff @(posedge clk) begin
    if (!reset) key_q <= 1'b1;
    else        key_q <= key;
  end

  assign press = key & ~key_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer: idle/play/pause/resume/over FSM, blinking pause overlay,
// resume countdown and gating of the frame tick to the game datapath.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int BLINK_TICKS  = BLINK_TICKS_DEF,
  parameter int RESUME_TICKS = RESUME_TICKS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_pause,
  input  logic       key_flap,
  input  logic       collision,
  input  logic       tick,
  output logic       game_en,
  output logic       pause,
  output logic       new_game,
  output logic       over,
  output logic [2:0] state,
  output logic [1:0] count
);

  localparam int          BW          = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [1:0]  RESUME_LOAD = 2'(RESUME_TICKS);

  logic press_pause, press_flap;

  key_edge u_pause_edge (.clk(clk), .reset(reset), .key(key_pause), .press(press_pause));
  key_edge u_flap_edge  (.clk(clk), .reset(reset), .key(key_flap),  .press(press_flap));

  game_state_t   state_q, state_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [1:0]    count_q, count_d;
  logic          new_game_q, new_game_d;
  logic          pause_q, pause_d;
  logic          over_q, over_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      blink_q    <= '0;
      phase_q    <= 1'b1;
      count_q    <= 2'd0;
      new_game_q <= 1'b0;
      pause_q    <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      blink_q    <= blink_d;
      phase_q    <= phase_d;
      count_q    <= count_d;
      new_game_q <= new_game_d;
      pause_q    <= pause_d;
      over_q     <= over_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    blink_d    = blink_q;
    phase_d    = phase_q;
    count_d    = count_q;
    new_game_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_flap) begin
          state_d    = PLAY;
          new_game_d = 1'b1;
        end
      end
      PLAY: begin
        if (collision) begin
          state_d = OVER;
        end else if (press_pause) begin
          state_d = PAUSED;
          blink_d = '0;
          phase_d = 1'b1;
        end
      end
      PAUSED: begin
        if (press_pause) begin
          state_d = RESUME;
          count_d = RESUME_LOAD;
        end else if (tick) begin
          if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
          end else begin
            blink_d = blink_q + BW'(1);
          end
        end
      end
      RESUME: begin
        // A re-pause beats the final countdown tick.
        if (press_pause) begin
          state_d = PAUSED;
          count_d = 2'd0;
          blink_d = '0;
          phase_d = 1'b1;
        end else if (tick) begin
          if (count_q == 2'd1) begin
            state_d = PLAY;
            count_d = 2'd0;
          end else begin
            count_d = count_q - 2'd1;
          end
        end
      end
      OVER: begin
        if (press_flap) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = 2'd0;
      end
    endcase
    pause_d = (state_d == PAUSED) & phase_d;
    over_d  = (state_d == OVER);
  end

  assign game_en  = tick & (state_q == PLAY);
  assign pause    = pause_q;
  assign new_game = new_game_q;
  assign over     = over_q;
  assign state    = state_q;
  assign count    = count_q;

endmodule
